// File: rtl/fxp_mul_scheduler.sv
// Round-robin arbiter that time-shares one external combinational fixed-point
// multiplier among NREQ requesters and returns tagged, registered results.
module fxp_mul_scheduler #(
    parameter int NREQ = 4,
    parameter int WI1  = 3,
    parameter int WF1  = 4,
    parameter int WI2  = 4,
    parameter int WF2  = 3,
    parameter int WIO  = WI1 + WI2,
    parameter int WFO  = WF1 + WF2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*(WI1+WF1)-1:0]     req_a,
    input  logic [NREQ*(WI2+WF2)-1:0]     req_b,
    output logic [WI1+WF1-1:0]            mul_in1,
    output logic [WI2+WF2-1:0]            mul_in2,
    input  logic [WIO+WFO-1:0]            mul_out,
    input  logic                          mul_ovf,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WIO+WFO-1:0]            rsp_data,
    output logic                          rsp_ovf,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [7:0]                    ovf_cnt
);

    localparam int W1  = WI1 + WF1;
    localparam int W2  = WI2 + WF2;
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [W1-1:0]   op1;
    logic [W2-1:0]   op2;
    logic [IDW-1:0]  grant;
    logic            grant_vld;
    int              idx;

    // Circular search from ptr: walking the offsets downward lets the
    // smallest offset (highest priority) overwrite any earlier hit.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                grant     = IDW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld) req_ready[grant] = 1'b1;
    end

    assign mul_in1 = op1;
    assign mul_in2 = op2;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op1       <= '0;
            op2       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            rsp_id    <= '0;
            ovf_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op1    <= req_a[grant*W1 +: W1];
                        op2    <= req_b[grant*W2 +: W2];
                        rsp_id <= grant;
                        ptr    <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= mul_out;
                    rsp_ovf   <= mul_ovf;
                    if (mul_ovf && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_mul_scheduler.sv
// Directed bench for fxp_mul_scheduler with a behavioural signed multiplier
// standing in for the shared external multiplier.
module tb_fxp_mul_scheduler;

    localparam int NREQ = 4;
    localparam int W1   = 7;
    localparam int W2   = 7;
    localparam int WO   = 14;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W1-1:0]   req_a;
    logic [NREQ*W2-1:0]   req_b;
    logic [W1-1:0]        mul_in1;
    logic [W2-1:0]        mul_in2;
    logic [WO-1:0]        mul_out;
    logic                 mul_ovf;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WO-1:0]        rsp_data;
    logic                 rsp_ovf;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           ovf_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Operand tables: Q3.4 a, Q4.3 b, and hand-computed Q7.7 products.
    logic [W1-1:0] a_tab [NREQ] = '{7'h10, 7'h20, 7'h18, 7'h70};
    logic [W2-1:0] b_tab [NREQ] = '{7'h08, 7'h08, 7'h14, 7'h08};
    logic [WO-1:0] p_tab [NREQ] = '{14'h0080, 14'h0100, 14'h01E0, 14'h3F80};

    logic force_ovf;
    logic signed [WO-1:0] a_ext, b_ext;
    assign a_ext   = {{(WO-W1){mul_in1[W1-1]}}, mul_in1};
    assign b_ext   = {{(WO-W2){mul_in2[W2-1]}}, mul_in2};
    assign mul_out = a_ext * b_ext;
    assign mul_ovf = force_ovf;

    always #5 clk = ~clk;

    fxp_mul_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_in1(mul_in1), .mul_in2(mul_in2),
        .mul_out(mul_out), .mul_ovf(mul_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .rsp_id(rsp_id), .ovf_cnt(ovf_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance through EXEC and RESP back to IDLE with rsp_ready held high.
    task automatic drain();
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        n_tests++; if (rsp_data !== 14'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", rsp_data); end
        n_tests++; if (rsp_ovf !== 1'b0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_ovf_id got %b/%0d want 0/0", rsp_ovf, rsp_id); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", ovf_cnt); end
        n_tests++; if (mul_in1 !== 7'h0 || mul_in2 !== 7'h0) begin n_fail++; $display("FAIL reset_mul_in got %h/%h want 00/00", mul_in1, mul_in2); end
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        #1;
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_tests++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec got ready=%b valid=%b want 0000/0", req_ready, rsp_valid); end
        n_tests++; if (mul_in1 !== 7'h18 || mul_in2 !== 7'h14) begin n_fail++; $display("FAIL single_mul_in got %h/%h want 18/14", mul_in1, mul_in2); end
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        n_tests++; if (rsp_data !== 14'h01E0) begin n_fail++; $display("FAIL single_data got %h want 01e0", rsp_data); end
        n_tests++; if (rsp_id !== 2'd2 || rsp_ovf !== 1'b0 || ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL single_tag got id=%0d ovf=%b cnt=%0d want 2/0/0", rsp_id, rsp_ovf, ovf_cnt); end
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_release got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % NREQ;
            #1;
            n_tests++; if (req_ready !== 4'(1 << e)) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 4'(1 << e)); end
            @(negedge clk);
            n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_exec_ready%0d got %b want 0000", k, req_ready); end
            @(negedge clk);
            n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(e)) begin n_fail++; $display("FAIL rr_rsp%0d got valid=%b id=%0d want 1/%0d", k, rsp_valid, rsp_id, e); end
            n_tests++; if (rsp_data !== p_tab[e]) begin n_fail++; $display("FAIL rr_data%0d got %h want %h", k, rsp_data, p_tab[e]); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back_backpressure();
        // ptr is 1 here; requesters 1 and 3 compete.
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got %b want 0010", req_ready); end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            req_valid = (c % 2 == 0) ? 4'b1111 : 4'b1010;
            #1;
            n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 14'h0100) begin n_fail++; $display("FAIL bp_hold%0d got valid=%b id=%0d data=%h want 1/1/0100", c, rsp_valid, rsp_id, rsp_data); end
            n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got %b want 0000", c, req_ready); end
            @(negedge clk);
        end
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_next_grant got %b want 1000", req_ready); end
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        force_ovf = 1'b1;
        req_valid = 4'b0001;
        for (int n = 1; n <= 260; n++) begin
            int exp_cnt;
            exp_cnt = (n > 255) ? 255 : n;
            for (int c = 0; c < 10 && rsp_valid !== 1'b1; c++) @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1) begin
                n_fail++; $display("FAIL ovf_timeout result %0d got valid=%b want 1", n, rsp_valid);
                break;
            end
            n_tests++; if (rsp_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag%0d got %b want 1", n, rsp_ovf); end
            n_tests++; if (ovf_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL ovf_cnt%0d got %0d want %0d", n, ovf_cnt, exp_cnt); end
            if (n == 260) req_valid = '0;
            @(negedge clk);
        end
        force_ovf = 1'b0;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        // ptr is 1; granting requester 2 moves it to 3 before the abort.
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (rsp_valid !== 1'b0 || rsp_data !== 14'h0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_outputs got valid=%b data=%h id=%0d want 0/0000/0", rsp_valid, rsp_data, rsp_id); end
        n_tests++; if (ovf_cnt !== 8'd0 || mul_in1 !== 7'h0 || mul_in2 !== 7'h0) begin n_fail++; $display("FAIL mid_state got cnt=%0d in=%h/%h want 0/00/00", ovf_cnt, mul_in1, mul_in2); end
        repeat (2) begin
            @(negedge clk);
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp got %b want 0", rsp_valid); end
        end
        req_valid = 4'b1001;
        #1;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset got %b want 0001", req_ready); end
        drain();
    endtask

    task automatic test_fairness_idle();
        // ptr is 1 after the previous grant of requester 0.
        req_valid = 4'b1000;
        #1;
        n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL fair_grant3 got %b want 1000", req_ready); end
        drain();
        for (int c = 0; c < 10; c++) begin
            n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL fair_idle%0d got %b want 0000", c, req_ready); end
            @(negedge clk);
        end
        req_valid = 4'b1001;
        #1;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fair_first got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL fair_second got %b want 1000", req_ready); end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        force_ovf = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W1 +: W1] = a_tab[i];
            req_b[i*W2 +: W2] = b_tab[i];
        end
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_backpressure();
        test_overflow();
        test_reset_mid();
        test_fairness_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
